tlul_sram_slave: RTL and testbench
==================================

// Module: tlul_sram_slave
// PURPOSE
// TL-UL slave endpoint on the 24 MHz side of the interconnect; consumes slave_a_* from xbar_peri, returns slave_d_*.
// Backs a word-addressed SRAM with byte-lane writes. Checks each request and returns a TL-UL AccessAck or AccessAckData.
// One request is outstanding at a time. Response latency is 1 cycle. Full throughput when d_ready is held high.
// PARAMETERS
// ADDR_WIDTH   32            byte address width
// DATA_WIDTH   32            data width; only 32 is supported
// MASK_WIDTH   DATA_WIDTH/8  byte-lane mask width
// SIZE_WIDTH   3             TL-UL log2(bytes) size field
// OPCODE_WIDTH 3             TL-UL opcode width
// PARAM_WIDTH  3             TL-UL param width
// MEM_DEPTH    256           number of 32-bit words
// BASE_ADDR    32'h0         byte address of word 0
// PORTS
// clk        in   1             clock (clk_24 domain at top level)
// reset_n    in   1             synchronous reset, active-low
// a_valid    in   1             request valid
// a_ready    out  1             request accepted when a_valid & a_ready
// a_opcode   in   OPCODE_WIDTH  0=PutFullData, 1=PutPartialData, 4=Get
// a_param    in   PARAM_WIDTH   ignored
// a_size     in   SIZE_WIDTH    log2 of transfer bytes
// a_source   in   1             source ID, echoed on d_source
// a_address  in   ADDR_WIDTH    byte address
// a_mask     in   MASK_WIDTH    byte-lane enables
// a_data     in   DATA_WIDTH    write data
// d_valid    out  1             response valid
// d_ready    in   1             response consumed when d_valid & d_ready
// d_opcode   out  OPCODE_WIDTH  0=AccessAck, 1=AccessAckData
// d_param    out  PARAM_WIDTH   always 0
// d_size     out  SIZE_WIDTH    echo of a_size
// d_source   out  1             echo of a_source
// d_sink     out  1             always 0
// d_data     out  DATA_WIDTH    read data; 0 for writes and errors
// d_error    out  1             request was rejected
// BEHAVIOUR
// - Reset (reset_n==0 at a clk edge): d_valid=0; d_opcode, d_size, d_source, d_data, d_error=0; a_ready=1 in the next cycle.
// - SRAM contents are not reset.
// - a_ready = !d_valid | d_ready (combinational). The response slot may be refilled in the same cycle it drains.
// - Accept (a_valid & a_ready): at the next edge, d_valid=1 and all d_* fields are loaded from the request.
// - d_* are stable while d_valid & !d_ready. With no new accept, d_valid clears on the d_ready handshake.
// - Decode: off = a_address - BASE_ADDR; word index = off[ADDR_WIDTH-1:2].
// - Error conditions (any one sets d_error=1):
//   - opcode not in {0,1,4};
//   - a_size > 2;
//   - address not aligned to 2^a_size;
//   - a_address < BASE_ADDR, or word index >= MEM_DEPTH;
//   - PutFullData with a_mask != all-ones for the lanes of a_size;
//   - Put with a_mask == 0.
// - On error: no SRAM write; d_data=0; d_opcode = 1 for Get, otherwise 0.
// - Put, no error: at the accept edge, write every byte lane i with a_mask[i]=1. Response d_opcode=0, d_data=0.
// - Get, no error: the full word is read at the accept edge and returned as d_data with d_opcode=1. a_mask is ignored.
// - Read after write: a Get accepted the cycle after a Put to the same word returns the new data (write-first).
// - reset_n low mid-response: the pending response is dropped; d_valid=0 after the edge.
// STRUCTURE
// - tlul_pkg: opcode constants (TL_PUT_FULL=3'd0, TL_PUT_PARTIAL=3'd1, TL_GET=3'd4, TL_ACK=3'd0, TL_ACK_DATA=3'd1).
// - Sub-module tlul_sram_mem: single-port MEM_DEPTH x 32 array with byte enables and registered read.
// - The top contains the error checks, the response register and the handshake logic.
// TESTING
// 1. Reset, then idle: d_valid=0, a_ready=1; no response appears without a request.
// 2. PutFull 0xDEADBEEF at 0x10 (mask 4'hF, size 2) then Get 0x10:
//    -> AccessAck err=0, then AccessAckData data=0xDEADBEEF. Each response 1 cycle after its accept.
// 3. PutPartial mask 4'b0010, data 0x0000AB00 at 0x10, then Get 0x10 -> data=0xDEADABEF.
// 4. Errors:
//    - Get at 0x402 with MEM_DEPTH=256 -> d_error=1, d_opcode=1, d_data=0.
//    - PutFull at 0x11 -> d_error=1, d_opcode=0; memory unchanged.
//    - opcode 2 -> d_error=1.
// 5. Backpressure: hold d_ready=0 for 5 cycles after a Get.
//    -> d_* stable; a_ready=0; second request is not accepted until d_ready=1.
// 6. Back-to-back 8 Gets with d_ready=1: one response per cycle, d_source echoed (alternating 0/1);
//    assert reset_n=0 mid-burst -> d_valid=0 on the next cycle.

Source files
------------

// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// Shared TL-UL definitions for the SRAM slave: A/D channel opcode encodings and
// a helper that returns the byte lanes covered by a transfer of a given size.
// -----------------------------------------------------------------------------
package tlul_pkg;

   // A-channel request opcodes
   localparam logic [2:0] TL_PUT_FULL    = 3'd0;
   localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] TL_GET         = 3'd4;

   // D-channel response opcodes
   localparam logic [2:0] TL_ACK         = 3'd0;
   localparam logic [2:0] TL_ACK_DATA    = 3'd1;

   // Byte lanes touched by a naturally aligned transfer of 2^size bytes
   // starting at byte offset addr_lo within a 32-bit word.
   function automatic logic [3:0] size_lane_mask(input logic [2:0] size,
                                                 input logic [1:0] addr_lo);
      logic [3:0] lanes;
      case (size)
         3'd0:    lanes = 4'b0001 << addr_lo;
         3'd1:    lanes = 4'b0011 << addr_lo;
         default: lanes = 4'b1111;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/tlul_sram_mem.sv
// -----------------------------------------------------------------------------
// tlul_sram_mem
// Single-port DEPTH x 32 SRAM with per-byte write enables and a registered read.
// A write and a read never happen in the same cycle (the slave issues at most
// one access per accept).
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   re     in   read strobe; rdata updates only when re=1
//   addr   in   word index
//   wmask  in   byte-lane write enables
//   wdata  in   write data
//   rdata  out  registered read data, held between reads
// -----------------------------------------------------------------------------
module tlul_sram_mem #(
   parameter int DEPTH  = 256,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [IDX_W-1:0] addr,
   input  logic [3:0]       wmask,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];

   // NOTE: the array has no reset branch on purpose; resetting a RAM turns it
   // into a huge register file and real SRAM macros cannot be cleared anyway.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/tlul_sram_slave.sv
// -----------------------------------------------------------------------------
// tlul_sram_slave
// TL-UL slave endpoint backing a word-addressed SRAM with byte-lane writes.
// Each request is checked; legal Puts write the SRAM and get an AccessAck,
// legal Gets read the SRAM and get an AccessAckData. Illegal requests are
// answered with d_error=1 and never touch the SRAM. A single response slot
// gives one outstanding request and full throughput while d_ready is high.
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   a_valid/a_ready        A-channel handshake
//   a_opcode..a_data       A-channel request fields (a_param ignored)
//   d_valid/d_ready        D-channel handshake
//   d_opcode..d_error      D-channel response fields (d_param, d_sink = 0)
// -----------------------------------------------------------------------------
module tlul_sram_slave
   import tlul_pkg::*;
#(
   parameter int                  ADDR_WIDTH   = 32,
   parameter int                  DATA_WIDTH   = 32,
   parameter int                  MASK_WIDTH   = DATA_WIDTH / 8,
   parameter int                  SIZE_WIDTH   = 3,
   parameter int                  OPCODE_WIDTH = 3,
   parameter int                  PARAM_WIDTH  = 3,
   parameter int                  MEM_DEPTH    = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [OPCODE_WIDTH-1:0] a_opcode,
   input  logic [PARAM_WIDTH-1:0]  a_param,
   input  logic [SIZE_WIDTH-1:0]   a_size,
   input  logic                    a_source,
   input  logic [ADDR_WIDTH-1:0]   a_address,
   input  logic [MASK_WIDTH-1:0]   a_mask,
   input  logic [DATA_WIDTH-1:0]   a_data,
   output logic                    d_valid,
   input  logic                    d_ready,
   output logic [OPCODE_WIDTH-1:0] d_opcode,
   output logic [PARAM_WIDTH-1:0]  d_param,
   output logic [SIZE_WIDTH-1:0]   d_size,
   output logic                    d_source,
   output logic                    d_sink,
   output logic [DATA_WIDTH-1:0]   d_data,
   output logic                    d_error
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);

   logic                  accept;
   logic [ADDR_WIDTH-1:0] off;
   logic [ADDR_WIDTH-3:0] word_idx;
   logic                  is_put;
   logic                  is_get;
   logic                  err_opcode;
   logic                  err_size;
   logic                  err_align;
   logic                  err_range;
   logic                  err_full_mask;
   logic                  err_zero_mask;
   logic                  req_err;
   logic                  mem_we;
   logic                  mem_re;
   logic [31:0]           mem_rdata;
   logic                  rsp_rd;     // response carries SRAM read data
   logic                  unused_bits;

   // The slot can take a new request whenever it is empty or draining now.
   assign a_ready = !d_valid | d_ready;
   assign accept  = a_valid & a_ready;

   // ---------------------------------------------------------------- decode
   assign off      = a_address - BASE_ADDR;
   assign word_idx = off[ADDR_WIDTH-1:2];
   assign is_put   = (a_opcode == TL_PUT_FULL) | (a_opcode == TL_PUT_PARTIAL);
   assign is_get   = (a_opcode == TL_GET);

   // NOTE: every signal written here gets a value before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      err_align = 1'b0;
      case (a_size)
         SIZE_WIDTH'(1): err_align = a_address[0];
         SIZE_WIDTH'(2): err_align = |a_address[1:0];
         default:        err_align = 1'b0;   // size 0 is always aligned, >2 flagged below
      endcase
   end

   assign err_opcode    = !(is_put | is_get);
   assign err_size      = a_size > SIZE_WIDTH'(2);
   assign err_range     = (a_address < BASE_ADDR) | (word_idx >= DEPTH_WORDS);
   assign err_full_mask = (a_opcode == TL_PUT_FULL) &&
                          (a_mask != size_lane_mask(a_size, a_address[1:0]));
   assign err_zero_mask = is_put && (a_mask == '0);
   assign req_err       = err_opcode | err_size | err_align | err_range |
                          err_full_mask | err_zero_mask;

   // Accesses are suppressed while reset is asserted so a request that happens
   // to be presented during reset cannot corrupt the SRAM.
   assign mem_we = accept & is_put & !req_err & reset_n;
   assign mem_re = accept & is_get & !req_err & reset_n;

   tlul_sram_mem #(
      .DEPTH (MEM_DEPTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (word_idx[IDX_W-1:0]),
      .wmask (a_mask),
      .wdata (a_data),
      .rdata (mem_rdata)
   );

   // ------------------------------------------------------- response slot
   // NOTE: state registers use <= so every flop samples pre-edge values;
   // blocking assignments here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         d_valid  <= 1'b0;
         d_opcode <= '0;
         d_size   <= '0;
         d_source <= 1'b0;
         d_error  <= 1'b0;
         rsp_rd   <= 1'b0;
      end else if (accept) begin
         d_valid  <= 1'b1;
         d_opcode <= is_get ? TL_ACK_DATA : TL_ACK;
         d_size   <= a_size;
         d_source <= a_source;
         d_error  <= req_err;
         rsp_rd   <= mem_re;
      end else if (d_ready) begin
         d_valid  <= 1'b0;
      end
   end

   // The SRAM read register only changes on a legal Get accept, so it stays
   // stable for as long as the response is stalled.
   assign d_data  = rsp_rd ? mem_rdata : '0;
   assign d_param = '0;
   assign d_sink  = 1'b0;

   assign unused_bits = ^{a_param, off[1:0]};

endmodule

// File: tb/tb_tlul_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_tlul_sram_slave
// Directed bench for tlul_sram_slave: reset/idle, Put/Get round trips, partial
// writes, error responses, backpressure and a back-to-back burst with reset.
// -----------------------------------------------------------------------------
module tb_tlul_sram_slave;
   import tlul_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_opcode;
   logic [2:0]  a_param;
   logic [2:0]  a_size;
   logic        a_source;
   logic [31:0] a_address;
   logic [3:0]  a_mask;
   logic [31:0] a_data;
   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [2:0]  d_param;
   logic [2:0]  d_size;
   logic        d_source;
   logic        d_sink;
   logic [31:0] d_data;
   logic        d_error;

   int n_vec = 0;
   int n_err = 0;

   tlul_sram_slave dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_opcode  (a_opcode),
      .a_param   (a_param),
      .a_size    (a_size),
      .a_source  (a_source),
      .a_address (a_address),
      .a_mask    (a_mask),
      .a_data    (a_data),
      .d_valid   (d_valid),
      .d_ready   (d_ready),
      .d_opcode  (d_opcode),
      .d_param   (d_param),
      .d_size    (d_size),
      .d_source  (d_source),
      .d_sink    (d_sink),
      .d_data    (d_data),
      .d_error   (d_error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request; it is accepted at the next edge. Returns #1 after it.
   task automatic send(input string tag, input logic [2:0] op, input logic [2:0] sz,
                       input logic src, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data);
      a_valid   = 1'b1;
      a_opcode  = op;
      a_param   = 3'd5;
      a_size    = sz;
      a_source  = src;
      a_address = addr;
      a_mask    = mask;
      a_data    = data;
      #1;
      check({tag, "_a_ready"}, 32'(a_ready), 32'd1);
      @(posedge clk); #1;
      a_valid = 1'b0;
   endtask

   task automatic expect_rsp(input string tag, input logic [2:0] op, input logic err,
                             input logic [31:0] data, input logic src, input logic [2:0] sz);
      check({tag, "_d_valid"},  32'(d_valid),  32'd1);
      check({tag, "_d_opcode"}, 32'(d_opcode), 32'(op));
      check({tag, "_d_error"},  32'(d_error),  32'(err));
      check({tag, "_d_data"},   d_data,        data);
      check({tag, "_d_source"}, 32'(d_source), 32'(src));
      check({tag, "_d_size"},   32'(d_size),   32'(sz));
      check({tag, "_d_param"},  32'({d_param, d_sink}), 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      a_valid   = 1'b0;
      a_opcode  = '0;
      a_param   = '0;
      a_size    = '0;
      a_source  = 1'b0;
      a_address = '0;
      a_mask    = '0;
      a_data    = '0;
      d_ready   = 1'b1;

      // 1. reset and idle
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("rst_d_valid",  32'(d_valid),  32'd0);
      check("rst_a_ready",  32'(a_ready),  32'd1);
      check("rst_d_opcode", 32'(d_opcode), 32'd0);
      check("rst_d_error",  32'(d_error),  32'd0);
      check("rst_d_data",   d_data,        32'd0);
      check("rst_d_size",   32'({d_size, d_source}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("idle_d_valid", 32'(d_valid), 32'd0);
      end

      // 2. full write then read back, each response one cycle after accept
      send("put_full", TL_PUT_FULL, 3'd2, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
      expect_rsp("put_full", TL_ACK, 1'b0, 32'h0, 1'b0, 3'd2);
      send("get1", TL_GET, 3'd2, 1'b1, 32'h10, 4'h0, 32'h0);
      expect_rsp("get1", TL_ACK_DATA, 1'b0, 32'hDEADBEEF, 1'b1, 3'd2);

      // 3. partial write of lane 1
      send("put_part", TL_PUT_PARTIAL, 3'd2, 1'b0, 32'h10, 4'b0010, 32'h0000AB00);
      expect_rsp("put_part", TL_ACK, 1'b0, 32'h0, 1'b0, 3'd2);
      send("get2", TL_GET, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0);
      expect_rsp("get2", TL_ACK_DATA, 1'b0, 32'hDEADABEF, 1'b0, 3'd2);

      // 4. error responses
      send("err_range", TL_GET, 3'd2, 1'b1, 32'h402, 4'hF, 32'h0);
      expect_rsp("err_range", TL_ACK_DATA, 1'b1, 32'h0, 1'b1, 3'd2);
      send("err_align", TL_PUT_FULL, 3'd2, 1'b0, 32'h11, 4'hF, 32'h12345678);
      expect_rsp("err_align", TL_ACK, 1'b1, 32'h0, 1'b0, 3'd2);
      send("err_op2", 3'd2, 3'd2, 1'b0, 32'h10, 4'hF, 32'h55555555);
      expect_rsp("err_op2", TL_ACK, 1'b1, 32'h0, 1'b0, 3'd2);
      send("err_size3", TL_GET, 3'd3, 1'b0, 32'h10, 4'hF, 32'h0);
      expect_rsp("err_size3", TL_ACK_DATA, 1'b1, 32'h0, 1'b0, 3'd3);
      send("err_mask0", TL_PUT_PARTIAL, 3'd2, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
      expect_rsp("err_mask0", TL_ACK, 1'b1, 32'h0, 1'b1, 3'd2);
      send("err_fullmask", TL_PUT_FULL, 3'd0, 1'b0, 32'h12, 4'hF, 32'h00990000);
      expect_rsp("err_fullmask", TL_ACK, 1'b1, 32'h0, 1'b0, 3'd0);
      send("err_word256", TL_GET, 3'd2, 1'b0, 32'h400, 4'hF, 32'h0);
      expect_rsp("err_word256", TL_ACK_DATA, 1'b1, 32'h0, 1'b0, 3'd2);
      // none of the rejected writes may have reached the SRAM
      send("get_after_err", TL_GET, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0);
      expect_rsp("get_after_err", TL_ACK_DATA, 1'b0, 32'hDEADABEF, 1'b0, 3'd2);

      // legal byte write, then last word of the array
      send("put_byte", TL_PUT_FULL, 3'd0, 1'b1, 32'h12, 4'b0100, 32'h00770000);
      expect_rsp("put_byte", TL_ACK, 1'b0, 32'h0, 1'b1, 3'd0);
      send("get3", TL_GET, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0);
      expect_rsp("get3", TL_ACK_DATA, 1'b0, 32'hDE77ABEF, 1'b0, 3'd2);
      send("put_last", TL_PUT_FULL, 3'd2, 1'b0, 32'h3FC, 4'hF, 32'hCAFEF00D);
      expect_rsp("put_last", TL_ACK, 1'b0, 32'h0, 1'b0, 3'd2);
      send("get_last", TL_GET, 3'd2, 1'b1, 32'h3FC, 4'hF, 32'h0);
      expect_rsp("get_last", TL_ACK_DATA, 1'b0, 32'hCAFEF00D, 1'b1, 3'd2);

      // 5. backpressure
      @(posedge clk); #1;
      check("drain_d_valid", 32'(d_valid), 32'd0);
      d_ready = 1'b0;
      send("bp_get", TL_GET, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0);
      a_valid   = 1'b1;
      a_opcode  = TL_GET;
      a_size    = 3'd2;
      a_source  = 1'b1;
      a_address = 32'h3FC;
      a_mask    = 4'hF;
      for (int i = 0; i < 5; i++) begin
         check("bp_a_ready",  32'(a_ready),  32'd0);
         check("bp_d_valid",  32'(d_valid),  32'd1);
         check("bp_d_opcode", 32'(d_opcode), 32'(TL_ACK_DATA));
         check("bp_d_source", 32'(d_source), 32'd0);
         check("bp_d_data",   d_data,        32'hDE77ABEF);
         @(posedge clk); #1;
      end
      d_ready = 1'b1;
      #1;
      check("bp_release_a_ready", 32'(a_ready), 32'd1);
      @(posedge clk); #1;
      a_valid = 1'b0;
      expect_rsp("bp_second", TL_ACK_DATA, 1'b0, 32'hCAFEF00D, 1'b1, 3'd2);

      // 6. back-to-back Gets, reset asserted mid-burst
      for (int i = 0; i < 8; i++) begin
         a_valid   = 1'b1;
         a_opcode  = TL_GET;
         a_size    = 3'd2;
         a_source  = i[0];
         a_address = i[0] ? 32'h3FC : 32'h10;
         a_mask    = 4'hF;
         if (i == 5) reset_n = 1'b0;
         @(posedge clk); #1;
         if (i < 5) begin
            check("burst_d_valid",  32'(d_valid),  32'd1);
            check("burst_d_source", 32'(d_source), 32'(i[0]));
            check("burst_d_data",   d_data,        i[0] ? 32'hCAFEF00D : 32'hDE77ABEF);
         end else begin
            check("burst_rst_d_valid", 32'(d_valid), 32'd0);
            check("burst_rst_d_data",  d_data,       32'd0);
            break;
         end
      end
      a_valid = 1'b0;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_d_valid", 32'(d_valid), 32'd0);
      check("post_rst_a_ready", 32'(a_ready), 32'd1);

      // SRAM contents survive reset
      send("get_post_rst", TL_GET, 3'd2, 1'b0, 32'h3FC, 4'hF, 32'h0);
      expect_rsp("get_post_rst", TL_ACK_DATA, 1'b0, 32'hCAFEF00D, 1'b0, 3'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
